// File: rtl/g_prbs_chk.sv
// Serial PRBS checker for XNOR-feedback LFSR patterns (x^N + x^TAP + 1).
// It self-synchronises in HUNT, then free-runs in LOCKED to count bit errors.
`timescale 1ns/1ps
module g_prbs_chk #(
    parameter int POLY_LEN  = 7,
    parameter int TAP       = 6,
    parameter int LOCK_CNT  = 16,
    parameter int WIN_LEN   = 64,
    parameter int LOSS_ERR  = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 CK,
    input  logic                 CD,
    input  logic                 DV,
    input  logic                 DIN,
    input  logic                 CLR_CNT,
    output logic                 LOCK,
    output logic                 ERR,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam int FILL_W  = $clog2(POLY_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(LOSS_ERR + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(POLY_LEN);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  WERR_LOSS  = WERR_W'(LOSS_ERR);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                 state_reg;
    logic [POLY_LEN-1:0]    sr_reg;
    logic [FILL_W-1:0]      fill_cnt_reg;
    logic [MATCH_W-1:0]     match_cnt_reg;
    logic [WIN_W-1:0]       win_cnt_reg;
    logic [WERR_W-1:0]      win_err_reg;
    logic                   lock_reg;
    logic                   err_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;

    logic                   exp_bit;
    logic                   mis;
    logic                   sr_ones;
    logic                   win_wrap;
    logic [WERR_W-1:0]      win_err_next;
    logic [MATCH_W-1:0]     match_cnt_inc;

    always_comb begin
        exp_bit       = ~(sr_reg[POLY_LEN-1] ^ sr_reg[TAP-1]);
        mis           = DIN ^ exp_bit;
        // All-ones is the XNOR lockup state and must never qualify as a match.
        sr_ones       = &sr_reg;
        win_wrap      = (win_cnt_reg == WIN_LAST);
        // An error in the wrap cycle is the first error of the new window.
        win_err_next  = win_wrap ? WERR_W'(mis) : win_err_reg + WERR_W'(mis);
        match_cnt_inc = match_cnt_reg + MATCH_W'(1);
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state_reg     <= HUNT;
            sr_reg        <= '0;
            fill_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            lock_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            err_reg <= 1'b0;
            if (DV) begin
                case (state_reg)
                    HUNT: begin
                        sr_reg <= {sr_reg[POLY_LEN-2:0], DIN};
                        if (fill_cnt_reg != FILL_FULL) begin
                            fill_cnt_reg <= fill_cnt_reg + FILL_W'(1);
                        end else if (!mis && !sr_ones) begin
                            if (match_cnt_inc == MATCH_LOCK) begin
                                state_reg     <= LOCKED;
                                lock_reg      <= 1'b1;
                                win_cnt_reg   <= '0;
                                win_err_reg   <= '0;
                                match_cnt_reg <= '0;
                            end else begin
                                match_cnt_reg <= match_cnt_inc;
                            end
                        end else begin
                            match_cnt_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        // Feed back the prediction, not DIN, so a line error is seen once.
                        sr_reg      <= {sr_reg[POLY_LEN-2:0], exp_bit};
                        err_reg     <= mis;
                        win_cnt_reg <= win_wrap ? '0 : win_cnt_reg + WIN_W'(1);
                        win_err_reg <= win_err_next;
                        if (mis && (win_err_next == WERR_LOSS)) begin
                            state_reg     <= HUNT;
                            lock_reg      <= 1'b0;
                            fill_cnt_reg  <= '0;
                            match_cnt_reg <= '0;
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
            if (CLR_CNT) begin
                err_cnt_reg <= '0;
            end else if (DV && (state_reg == LOCKED) && mis && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign LOCK    = lock_reg;
    assign ERR     = err_reg;
    assign ERR_CNT = err_cnt_reg;

endmodule
